pack_rq0: RTL and testbench

// Packs an NTRU-HRSS Rq0 polynomial (public key h / ciphertext) into a stream of 13-bit coefficient pairs.

---
 rtl/pack_rq0_if.sv | 10 +
 rtl/pack_rq0.sv | 99 +++++++++
 tb/tb_pack_rq0.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pack_rq0_if.sv
// Pair stream from the Rq0 packer: one (even, odd) coefficient pair per valid/ready transfer.
interface pack_rq0_if;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] even;
  logic [12:0] odd;

  modport master (output out_valid, output even, output odd, input out_ready);
  modport slave  (input out_valid, input even, input odd, output out_ready);
endinterface

// File: rtl/pack_rq0.sv
// NTRU-HRSS Rq0 packer: streams coefficients 0..699 as 350 (even, odd) pairs and
// checks that all 701 coefficients sum to 0 mod 8192.
module pack_rq0 #(
  parameter int H_BITS           = 9113,
  parameter int EVEN_HALF_H_BITS = 4563,
  parameter int N_PAIRS          = 350
) (
  input  logic              clk,
  input  logic              ovr_rst,
  input  logic              i_start,
  input  logic [H_BITS:1]   i_h_in,
  pack_rq0_if.master        o_stream,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sum_ok
);
  localparam int SR_BITS = N_PAIRS * 13;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SR_BITS-1:0] r_even_sr;
  logic [SR_BITS-1:0] r_odd_sr;
  logic [12:0]        r_acc;
  logic [8:0]         r_k;
  logic               r_done;
  logic               r_sum_ok;

  logic               w_send;
  logic               w_load;
  logic               w_xfer;
  logic               w_last;
  logic [12:0]        w_even;
  logic [12:0]        w_odd;
  logic [12:0]        w_acc_sum;

  assign w_send    = (r_state == S_SEND);
  assign w_load    = i_start && !w_send;
  assign w_xfer    = w_send && o_stream.out_ready;
  assign w_last    = w_xfer && (r_k == 9'(N_PAIRS - 1));
  assign w_even    = w_send ? r_even_sr[12:0] : 13'd0;
  assign w_odd     = w_send ? r_odd_sr[12:0]  : 13'd0;
  // 13-bit wrap gives the mod-8192 running sum for free
  assign w_acc_sum = r_acc + w_even + w_odd;

  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_SEND;
      S_SEND:  if (w_last)  w_state_next = S_DONE;
      S_DONE:  if (i_start) w_state_next = S_SEND;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      r_even_sr <= '0;
      r_odd_sr  <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_done    <= 1'b0;
      r_sum_ok  <= 1'b0;
    end else if (w_load) begin
      // coefficient 700 seeds the accumulator; it is never shifted out
      r_even_sr <= i_h_in[SR_BITS:1];
      r_odd_sr  <= i_h_in[H_BITS:EVEN_HALF_H_BITS+1];
      r_acc     <= i_h_in[EVEN_HALF_H_BITS:SR_BITS+1];
      r_k       <= '0;
      r_done    <= 1'b0;
      r_sum_ok  <= 1'b0;
    end else if (w_xfer) begin
      r_even_sr <= {13'd0, r_even_sr[SR_BITS-1:13]};
      r_odd_sr  <= {13'd0, r_odd_sr[SR_BITS-1:13]};
      r_acc     <= w_acc_sum;
      r_k       <= r_k + 9'd1;
      if (w_last) begin
        r_done   <= 1'b1;
        r_sum_ok <= (w_acc_sum == 13'd0);
      end
    end
  end

  assign o_stream.out_valid = w_send;
  assign o_stream.even      = w_even;
  assign o_stream.odd       = w_odd;
  assign o_busy             = w_send;
  assign o_done             = r_done;
  assign o_sum_ok           = r_sum_ok;
endmodule

// File: tb/tb_pack_rq0.sv
// Randomized bench for pack_rq0 against a coefficient-level model of the pair stream.
module tb_pack_rq0;
  logic          clk = 1'b0;
  logic          ovr_rst;
  logic          start;
  logic [9113:1] h_in;
  logic          busy, done, sum_ok;

  pack_rq0_if intf ();

  pack_rq0 dut (
    .clk      (clk),
    .ovr_rst  (ovr_rst),
    .i_start  (start),
    .i_h_in   (h_in),
    .o_stream (intf),
    .o_busy   (busy),
    .o_done   (done),
    .o_sum_ok (sum_ok)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int poly [701];
  int m_coef [701];
  int m_st = 0;
  int m_idx = 0;
  int m_done = 0;
  int m_sumok = 0;
  int rx [700];
  int rx_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9113:1] pack_poly();
    logic [9113:1] h;
    h = '0;
    for (int k = 0; k <= 350; k++) h[13*k+1 +: 13] = 13'(poly[2*k]);
    for (int k = 0; k < 350; k++)  h[4563+13*k+1 +: 13] = 13'(poly[2*k+1]);
    return h;
  endfunction

  // Model: polynomial snapshot at load, pair index, done/sum flags derived from the whole sum.
  always @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      m_st = 0; m_idx = 0; m_done = 0; m_sumok = 0;
    end else if (m_st == 1) begin
      if (intf.out_ready) begin
        m_idx++;
        if (m_idx == 350) begin
          int s;
          s = 0;
          for (int i = 0; i < 701; i++) s += m_coef[i];
          m_st = 2; m_done = 1; m_sumok = (s % 8192 == 0) ? 1 : 0;
        end
      end
    end else if (start) begin
      for (int i = 0; i < 701; i++) m_coef[i] = poly[i];
      m_st = 1; m_idx = 0; m_done = 0; m_sumok = 0;
    end
  end

  always @(negedge clk) begin
    if (!ovr_rst) begin
      chk("out_valid", intf.out_valid, (m_st == 1) ? 1 : 0);
      chk("busy", busy, (m_st == 1) ? 1 : 0);
      chk("done", done, m_done);
      chk("sum_ok", sum_ok, m_done ? m_sumok : 0);
      chk("even", intf.even, (m_st == 1) ? m_coef[2*m_idx] : 0);
      chk("odd", intf.odd, (m_st == 1) ? m_coef[2*m_idx+1] : 0);
      if (intf.out_valid && intf.out_ready) begin
        if (rx_k < 350) begin
          rx[2*rx_k]   = int'(intf.even);
          rx[2*rx_k+1] = int'(intf.odd);
        end
        rx_k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input int c700);
    for (int i = 0; i < 700; i++) poly[i] = i;
    poly[700] = c700;
  endtask

  task automatic set_random();
    int s;
    s = 0;
    for (int i = 0; i < 700; i++) begin
      poly[i] = int'($urandom_range(0, 8191));
      s += poly[i];
    end
    poly[700] = (8192 - (s % 8192)) % 8192;
  endtask

  // mode 0: ready always 1; 1: ready pattern 1,0,0 with a stray start mid-stream; 2: random ready
  task automatic run_poly(input int mode, output int cycles);
    int mism;
    h_in = pack_poly();
    rx_k = 0;
    intf.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 3000) begin
      case (mode)
        0: intf.out_ready = 1'b1;
        1: intf.out_ready = (cycles % 3 == 0);
        default: intf.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && cycles == 50) begin
        start = 1'b1;
        h_in  = '0;
      end
      if (mode == 1 && cycles == 51) begin
        start = 1'b0;
        h_in  = pack_poly();
      end
      tick();
      cycles++;
    end
    intf.out_ready = 1'b1;
    chk("done_reached", done, 1);
    chk("xfer_count", rx_k, 350);
    mism = 0;
    for (int i = 0; i < 700; i++) if (rx[i] != poly[i]) mism++;
    chk("rx_stream", mism, 0);
  endtask

  initial begin
    int cyc;
    int s;
    int dones;
    ovr_rst = 1'b1;
    start = 1'b0;
    h_in = '0;
    intf.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", intf.out_valid, 0);
    chk("rst_even", intf.even, 0);
    chk("rst_odd", intf.odd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum_ok", sum_ok, 0);
    ovr_rst = 1'b0;
    tick();

    for (int i = 0; i < 701; i++) poly[i] = 0;
    run_poly(0, cyc);
    chk("zero_latency", cyc, 350);
    chk("zero_sum_ok", sum_ok, 1);

    set_ramp(1110);
    run_poly(0, cyc);
    chk("ramp_first_even", rx[0], 0);
    chk("ramp_first_odd", rx[1], 1);
    chk("ramp_last_even", rx[698], 698);
    chk("ramp_last_odd", rx[699], 699);
    chk("ramp_sum_ok", sum_ok, 1);

    set_ramp(1111);
    run_poly(0, cyc);
    chk("ramp1111_sum_ok", sum_ok, 0);

    set_ramp(1110);
    run_poly(1, cyc);
    chk("stall_sum_ok", sum_ok, 1);

    // abandon a stream part-way through with an asynchronous reset
    h_in = pack_poly();
    rx_k = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (rx_k < 100 && cyc < 500) begin tick(); cyc++; end
    chk("pre_reset_xfers", rx_k, 100);
    @(negedge clk);
    #2 ovr_rst = 1'b1;
    #1;
    chk("midrst_valid", intf.out_valid, 0);
    chk("midrst_even", intf.even, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    tick();
    ovr_rst = 1'b0;
    tick();
    run_poly(0, cyc);
    chk("restart_even", rx[0], 0);
    chk("restart_odd", rx[1], 1);

    // start held through two polynomials: the second one reloads straight from DONE
    set_random();
    h_in = pack_poly();
    rx_k = 0;
    start = 1'b1;
    tick();
    set_random();
    h_in = pack_poly();
    dones = 0;
    cyc = 0;
    while (dones < 2 && cyc < 2000) begin
      tick();
      cyc++;
      if (done) begin
        dones++;
        if (dones == 2) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_dones", dones, 2);
    chk("b2b_xfers", rx_k, 700);
    chk("b2b_cycles", cyc, 701);
    tick();

    for (int p = 0; p < 20; p++) begin
      set_random();
      run_poly(2, cyc);
      s = 0;
      for (int i = 0; i < 700; i++) s += rx[i];
      chk("recover_c700", (8192 - (s % 8192)) % 8192, poly[700]);
      chk("rand_sum_ok", sum_ok, 1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
